aes_cipher_collector: RTL and testbench
=======================================

// Module: aes_cipher_collector
// PURPOSE
//  Downstream of the byte-serial AES encryption core: samples the ciphertext byte stream (in_byte qualified by in_ready).
//  Reassembles 16 bytes into a 128-bit block and presents it on a valid/accept interface through a 2-entry output FIFO.
//  The core has no backpressure, so a full FIFO drops the block and raises a sticky overflow flag.
// PARAMETERS
//  LSB_FIRST  1  1: byte k of the stream -> out_data[8k+7:8k]; 0: byte k -> out_data[127-8k -: 8]
//  CNT_W      16 width of the completed-block counter blk_count (wraps)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_ready   in   1      core's ready: in_byte is valid on every cycle this is high
//  in_byte    in   8      ciphertext byte from the core
//  flush      in   1      discard any partial block, return to IDLE
//  out_data   out  128    head-of-FIFO ciphertext block
//  out_valid  out  1      FIFO non-empty
//  out_accept in   1      consumer takes head block when out_valid & out_accept
//  busy       out  1      high in COLLECT (partial block held)
//  overflow   out  1      sticky: a completed block was dropped (FIFO full); cleared only by rst
//  blk_count  out  CNT_W  completed blocks pushed into FIFO, modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst=1 at edge): FSM=IDLE, byte_idx=0, shift reg=0, FIFO empty, out_valid=0, out_data=0,
//   busy=0, overflow=0, blk_count=0. rst has priority over every other input.
//  FSM states:
//   IDLE     : in_ready=1 -> store byte at idx 0, byte_idx=1, go COLLECT
//   COLLECT  : in_ready=1 -> store byte at byte_idx, byte_idx++
//              on the 16th byte (byte_idx==15): push the block, byte_idx=0, go WAIT_LOW
//              in_ready=0 mid-block -> hold, stay in COLLECT (gaps allowed)
//   WAIT_LOW : ignore in_byte while in_ready=1 (guards a core that holds ready past the 16th byte);
//              in_ready=0 -> IDLE
//  flush=1 (rst=0): byte_idx=0, partial data discarded, next state IDLE, same-cycle byte ignored.
//   A block pushed on the same edge is still pushed.
//  Push:
//   - The block is the 15 stored bytes plus the current in_byte, written straight into the FIFO.
//   - out_valid rises the cycle after the 16th byte is sampled (1-cycle latency).
//   - blk_count increments on each successful push.
//  FIFO: depth 2. out_data/out_valid always reflect the head entry.
//   - Pop when out_valid & out_accept.
//   - Push and pop on the same edge are both performed, including when full (pop frees a slot first).
//   - out_accept while empty has no effect.
//  Full & push & no pop: block discarded, overflow<=1, blk_count unchanged; FSM still goes WAIT_LOW.
//  out_data is 0 when the FIFO is empty. busy = (state==COLLECT).
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  T1: rst, then 16 cycles in_ready=1, bytes 00..0F, out_accept=0
//      -> out_valid=1 next cycle; out_data=0F0E..0100 (LSB_FIRST=1); blk_count=1
//  T2: same stream with LSB_FIRST=0 -> out_data=00010203..0E0F
//  T3: bytes 8 and 9 separated by 5 in_ready=0 cycles -> identical block to T1, busy=1 throughout the gap
//  T4: in_ready held 20 cycles with bytes 00..13 -> one block 0F..00; bytes 10..13 ignored (WAIT_LOW);
//      no second block until in_ready falls and rises
//  T5: 3 back-to-back blocks (in_ready low 1 cycle between), out_accept=0
//      -> blocks 1 and 2 queued, block 3 dropped, overflow=1, blk_count=2;
//      then accept twice -> blocks 1 and 2 in order, out_valid=0
//  T6: flush after 7 bytes, then a full 16-byte block AA..B9 -> only AA..B9 emitted;
//      rst asserted mid-block -> all outputs back to reset values next cycle

Source files
------------

// File: rtl/aes_cipher_collector.sv
// Collects the byte-serial AES ciphertext stream into 128-bit blocks and
// queues them in a 2-entry FIFO; a block arriving at a full FIFO is dropped.
module aes_cipher_collector #(
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             flush,
  output logic [127:0]     out_data,
  output logic             out_valid,
  input  logic             out_accept,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_LOW} state_t;

  state_t       state;
  logic [3:0]   byte_idx;
  logic [127:0] shreg;
  logic [3:0]   byte_pos;
  logic [6:0]   bit_lo;
  logic [127:0] new_blk;
  logic         push_req;
  logic         pop;
  logic         do_push;
  logic [127:0] slot1;
  logic         valid1;

  // The completed block bypasses the shift register: 15 stored bytes plus the live byte.
  always_comb begin
    byte_pos = (LSB_FIRST != 0) ? byte_idx : 4'd15 - byte_idx;
    bit_lo   = {byte_pos, 3'b000};
    new_blk  = shreg;
    new_blk[bit_lo +: 8] = in_byte;
    push_req = (state == COLLECT) && in_ready && (byte_idx == 4'd15);
    pop      = out_valid && out_accept;
    do_push  = push_req && (!valid1 || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      shreg    <= '0;
    end else if (flush) begin
      state    <= IDLE;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready) begin
            shreg[bit_lo +: 8] <= in_byte;
            byte_idx           <= 4'd1;
            state              <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_ready) begin
            if (byte_idx == 4'd15) begin
              byte_idx <= '0;
              state    <= WAIT_LOW;
            end else begin
              shreg[bit_lo +: 8] <= in_byte;
              byte_idx           <= byte_idx + 4'd1;
            end
          end
        end
        WAIT_LOW: begin
          // A core holding ready high past the 16th byte must not start a new block.
          if (!in_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // out_data/out_valid are the head slot itself; slot1 is the second entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      slot1     <= '0;
      valid1    <= 1'b0;
      overflow  <= 1'b0;
      blk_count <= '0;
    end else begin
      if (push_req && !do_push) overflow <= 1'b1;
      if (do_push) blk_count <= blk_count + CNT_W'(1);
      if (pop) begin
        out_data  <= valid1 ? slot1 : '0;
        out_valid <= valid1;
        slot1     <= '0;
        valid1    <= 1'b0;
      end
      if (do_push) begin
        if (!out_valid || (pop && !valid1)) begin
          out_data  <= new_blk;
          out_valid <= 1'b1;
        end else begin
          slot1  <= new_blk;
          valid1 <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_aes_cipher_collector.sv
// Scoreboard bench for aes_cipher_collector; two instances (LSB_FIRST=1 and 0)
// share every input so both byte orders are checked on the same stream.
module tb_aes_cipher_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_ready = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         flush = 1'b0;
  logic         out_accept = 1'b0;
  logic [127:0] out_data1, out_data0;
  logic         out_valid1, out_valid0;
  logic         busy1, busy0;
  logic         overflow1, overflow0;
  logic [15:0]  blk_count1, blk_count0;

  logic [127:0] q1[$];
  logic [127:0] q0[$];
  logic [15:0]  exp_cnt;
  logic         exp_ovf;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  aes_cipher_collector #(.LSB_FIRST(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_byte(in_byte), .flush(flush),
    .out_data(out_data1), .out_valid(out_valid1), .out_accept(out_accept),
    .busy(busy1), .overflow(overflow1), .blk_count(blk_count1)
  );

  aes_cipher_collector #(.LSB_FIRST(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_byte(in_byte), .flush(flush),
    .out_data(out_data0), .out_valid(out_valid0), .out_accept(out_accept),
    .busy(busy0), .overflow(overflow0), .blk_count(blk_count0)
  );

  // Reference packing of 16 consecutive byte values starting at base.
  function automatic logic [127:0] pack(input logic [7:0] base, input bit lsb);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = base + 8'(k);
      if (lsb) r[8*k +: 8] = b;
      else     r[127-8*k -: 8] = b;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_ready = 1'b0; flush = 1'b0; out_accept = 1'b0; in_byte = 8'h00;
    tick();
    rst = 1'b0;
    q1.delete();
    q0.delete();
    exp_cnt = '0;
    exp_ovf = 1'b0;
  endtask

  // Drives one 16-byte block plus one idle cycle; the model decides push or drop.
  task automatic send_block(input logic [7:0] base, input bit accept_last);
    for (int k = 0; k < 16; k++) begin
      in_ready = 1'b1;
      in_byte  = base + 8'(k);
      if (k == 15) begin
        if (accept_last && q1.size() > 0) begin
          out_accept = 1'b1;
          void'(q1.pop_front());
          void'(q0.pop_front());
        end
        if (q1.size() < 2) begin
          q1.push_back(pack(base, 1'b1));
          q0.push_back(pack(base, 1'b0));
          exp_cnt = exp_cnt + 16'd1;
        end else begin
          exp_ovf = 1'b1;
        end
      end
      tick();
      out_accept = 1'b0;
    end
    in_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_ready = 1'b1; in_byte = 8'h77; flush = 1'b0; out_accept = 1'b1;
    tick();
    total++;
    if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_valid: got %0b/%0b want 0/0", out_valid1, out_valid0);
    end
    total++;
    if (out_data1 !== 128'h0 || out_data0 !== 128'h0) begin
      bad++; $display("[TB] FAIL reset_data: got %h/%h want 0", out_data1, out_data0);
    end
    total++;
    if (busy1 !== 1'b0 || overflow1 !== 1'b0 || blk_count1 !== 16'd0) begin
      bad++; $display("[TB] FAIL reset_flags: got busy=%0b ovf=%0b cnt=%0d want 0/0/0", busy1, overflow1, blk_count1);
    end
    do_reset();
  endtask

  task automatic test_lsb_first();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_ready = 1'b1;
      in_byte  = 8'(i);
      if (i == 15) begin
        q1.push_back(pack(8'h00, 1'b1));
        q0.push_back(pack(8'h00, 1'b0));
        exp_cnt = exp_cnt + 16'd1;
      end
      tick();
      if (i == 0) begin
        total++;
        if (busy1 !== 1'b1) begin bad++; $display("[TB] FAIL t1_busy_start: got %0b want 1", busy1); end
      end
      if (i == 14) begin
        total++;
        if (out_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL t1_early_valid: got %0b want 0", out_valid1); end
      end
    end
    in_ready = 1'b0;
    total++;
    if (out_valid1 !== 1'b1 || out_data1 !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      bad++; $display("[TB] FAIL t1_block: got v=%0b %h want 1 0f0e..0100", out_valid1, out_data1);
    end
    total++;
    if (out_valid0 !== 1'b1 || out_data0 !== 128'h000102030405060708090A0B0C0D0E0F) begin
      bad++; $display("[TB] FAIL t2_block: got v=%0b %h want 1 0001..0e0f", out_valid0, out_data0);
    end
    total++;
    if (blk_count1 !== exp_cnt || busy1 !== 1'b0) begin
      bad++; $display("[TB] FAIL t1_count: got cnt=%0d busy=%0b want %0d/0", blk_count1, busy1, exp_cnt);
    end
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    void'(q1.pop_front());
    void'(q0.pop_front());
    total++;
    if (out_valid1 !== 1'b0 || out_data1 !== 128'h0) begin
      bad++; $display("[TB] FAIL t1_pop: got v=%0b %h want 0 0", out_valid1, out_data1);
    end
  endtask

  task automatic test_gap();
    for (int i = 0; i < 16; i++) begin
      in_ready = 1'b1;
      in_byte  = 8'(i);
      if (i == 15) begin
        q1.push_back(pack(8'h00, 1'b1));
        q0.push_back(pack(8'h00, 1'b0));
        exp_cnt = exp_cnt + 16'd1;
      end
      tick();
      if (i == 8) begin
        in_ready = 1'b0;
        in_byte  = 8'hEE;
        for (int g = 0; g < 5; g++) begin
          tick();
          total++;
          if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
            bad++; $display("[TB] FAIL t3_gap%0d: got busy=%0b v=%0b want 1/0", g, busy1, out_valid1);
          end
        end
      end
    end
    in_ready = 1'b0;
    total++;
    if (out_data1 !== 128'h0F0E0D0C0B0A09080706050403020100 || out_data0 !== q0[0]) begin
      bad++; $display("[TB] FAIL t3_block: got %h/%h want %h/%h", out_data1, out_data0, q1[0], q0[0]);
    end
    total++;
    if (blk_count1 !== exp_cnt) begin bad++; $display("[TB] FAIL t3_count: got %0d want %0d", blk_count1, exp_cnt); end
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    void'(q1.pop_front());
    void'(q0.pop_front());
  endtask

  task automatic test_wait_low();
    for (int i = 0; i < 20; i++) begin
      in_ready = 1'b1;
      in_byte  = 8'(i);
      if (i == 15) begin
        q1.push_back(pack(8'h00, 1'b1));
        q0.push_back(pack(8'h00, 1'b0));
        exp_cnt = exp_cnt + 16'd1;
      end
      tick();
    end
    total++;
    if (blk_count1 !== exp_cnt || busy1 !== 1'b0) begin
      bad++; $display("[TB] FAIL t4_count: got cnt=%0d busy=%0b want %0d/0", blk_count1, busy1, exp_cnt);
    end
    total++;
    if (out_valid1 !== 1'b1 || out_data1 !== q1[0] || out_data0 !== q0[0]) begin
      bad++; $display("[TB] FAIL t4_head: got v=%0b %h/%h want %h/%h", out_valid1, out_data1, out_data0, q1[0], q0[0]);
    end
    in_byte    = 8'h55;
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    void'(q1.pop_front());
    void'(q0.pop_front());
    total++;
    if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++; $display("[TB] FAIL t4_no_second: got v=%0b busy=%0b want 0/0", out_valid1, busy1);
    end
    in_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_block(8'h10, 1'b0);
    send_block(8'h20, 1'b0);
    total++;
    if (overflow1 !== 1'b0 || out_valid1 !== 1'b1) begin
      bad++; $display("[TB] FAIL t5_two_queued: got ovf=%0b v=%0b want 0/1", overflow1, out_valid1);
    end
    send_block(8'h30, 1'b0);
    total++;
    if (overflow1 !== exp_ovf || overflow0 !== exp_ovf) begin
      bad++; $display("[TB] FAIL t5_overflow: got %0b/%0b want %0b", overflow1, overflow0, exp_ovf);
    end
    total++;
    if (blk_count1 !== exp_cnt || exp_cnt !== 16'd2) begin
      bad++; $display("[TB] FAIL t5_count: got %0d want 2", blk_count1);
    end
    for (int n = 0; n < 4 && q1.size() > 0; n++) begin
      total++;
      if (out_valid1 !== 1'b1 || out_data1 !== q1[0] || out_data0 !== q0[0]) begin
        bad++; $display("[TB] FAIL t5_head%0d: got v=%0b %h/%h want %h/%h", n, out_valid1, out_data1, out_data0, q1[0], q0[0]);
      end
      out_accept = 1'b1;
      tick();
      out_accept = 1'b0;
      void'(q1.pop_front());
      void'(q0.pop_front());
    end
    total++;
    if (out_valid1 !== 1'b0 || out_data1 !== 128'h0 || overflow1 !== 1'b1) begin
      bad++; $display("[TB] FAIL t5_drained: got v=%0b %h ovf=%0b want 0 0 1", out_valid1, out_data1, overflow1);
    end
    out_accept = 1'b1;
    tick();
    out_accept = 1'b0;
    total++;
    if (out_valid1 !== 1'b0 || blk_count1 !== 16'd2) begin
      bad++; $display("[TB] FAIL t5_empty_accept: got v=%0b cnt=%0d want 0/2", out_valid1, blk_count1);
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    send_block(8'h40, 1'b0);
    send_block(8'h60, 1'b0);
    send_block(8'h80, 1'b1);
    total++;
    if (overflow1 !== 1'b0 || blk_count1 !== exp_cnt) begin
      bad++; $display("[TB] FAIL full_pushpop: got ovf=%0b cnt=%0d want 0/%0d", overflow1, blk_count1, exp_cnt);
    end
    for (int n = 0; n < 4 && q1.size() > 0; n++) begin
      total++;
      if (out_valid1 !== 1'b1 || out_data1 !== q1[0] || out_data0 !== q0[0]) begin
        bad++; $display("[TB] FAIL full_head%0d: got v=%0b %h/%h want %h/%h", n, out_valid1, out_data1, out_data0, q1[0], q0[0]);
      end
      out_accept = 1'b1;
      tick();
      out_accept = 1'b0;
      void'(q1.pop_front());
      void'(q0.pop_front());
    end
    total++;
    if (out_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL full_drained: got %0b want 0", out_valid1); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_ready = 1'b1;
      in_byte  = 8'h50 + 8'(i);
      tick();
    end
    flush   = 1'b1;
    in_byte = 8'h99;
    tick();
    flush    = 1'b0;
    in_ready = 1'b0;
    total++;
    if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
      bad++; $display("[TB] FAIL t6_flush: got busy=%0b v=%0b want 0/0", busy1, out_valid1);
    end
    send_block(8'hAA, 1'b0);
    total++;
    if (out_data1 !== pack(8'hAA, 1'b1) || out_data0 !== pack(8'hAA, 1'b0) || blk_count1 !== 16'd1) begin
      bad++; $display("[TB] FAIL t6_block: got %h/%h cnt=%0d want %h cnt=1", out_data1, out_data0, blk_count1, pack(8'hAA, 1'b1));
    end
    for (int i = 0; i < 5; i++) begin
      in_ready = 1'b1;
      in_byte  = 8'hC0 + 8'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_ready = 1'b0;
    total++;
    if (busy1 !== 1'b0 || out_valid1 !== 1'b0 || out_data1 !== 128'h0 || blk_count1 !== 16'd0 || overflow1 !== 1'b0) begin
      bad++; $display("[TB] FAIL t6_rst_mid: got busy=%0b v=%0b d=%h cnt=%0d ovf=%0b want all 0", busy1, out_valid1, out_data1, blk_count1, overflow1);
    end
  endtask

  initial begin
    exp_cnt = '0;
    exp_ovf = 1'b0;
    test_reset();
    test_lsb_first();
    test_gap();
    test_wait_low();
    test_back_to_back();
    test_push_pop_full();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
